// File: rtl/lbus_tx_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one 512-bit LBUS TX path between
// NUM_SRC AXI4-Stream sources. A grant is held for a whole packet, so beats
// from two packets never interleave. Forwarding is zero-latency: the granted
// source is muxed straight through to the converter.
module lbus_tx_pkt_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [512*NUM_SRC-1:0]   s_axis_tdata,
  input  logic [64*NUM_SRC-1:0]    s_axis_tkeep,
  input  logic [NUM_SRC-1:0]       s_axis_tlast,
  input  logic [NUM_SRC-1:0]       s_axis_tvalid,
  output logic [NUM_SRC-1:0]       s_axis_tready,
  output logic [511:0]             m_axis_tdata,
  output logic [63:0]              m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [SEL_W-1:0]         grant_idx,
  output logic                     busy
);

  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   last_idx;
  logic               fwd;
  logic               eop;
  logic [NUM_SRC-1:0] req;
  logic [SEL_W-1:0]   pick;
  logic               pick_found;

  // Forwarding is only open while a packet is locked and reset is not active
  assign fwd = (state == PASS) && !rst;
  assign eop = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Zero-latency mux from the granted source to the converter, tready steering back
  always_comb begin
    m_axis_tdata  = s_axis_tdata[int'(grant_idx)*DATA_W +: DATA_W];
    m_axis_tkeep  = s_axis_tkeep[int'(grant_idx)*KEEP_W +: KEEP_W];
    m_axis_tlast  = s_axis_tlast[grant_idx];
    m_axis_tvalid = fwd && s_axis_tvalid[grant_idx];
    s_axis_tready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (fwd && (SEL_W'(i) == grant_idx)) begin
        s_axis_tready[i] = m_axis_tready;
      end
    end
  end

  // Requests are the tvalids, with the owner's bit dropped on its tlast handshake
  always_comb begin
    req = s_axis_tvalid;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (eop && (SEL_W'(i) == grant_idx)) begin
        req[i] = 1'b0;
      end
    end
  end

  // Round-robin search starting just after the last granted source, with wrap
  always_comb begin
    int unsigned c;
    c          = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      c = 32'(last_idx) + k;
      if (c >= NUM_SRC) begin
        c = c - NUM_SRC;
      end
      if (!pick_found && req[SEL_W'(c)]) begin
        pick       = SEL_W'(c);
        pick_found = 1'b1;
      end
    end
  end

  // Ownership FSM: arbitrate in IDLE, hold grant through PASS, re-arbitrate at packet end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_idx  <= SEL_W'(NUM_SRC - 1);
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx <= pick;
            last_idx  <= pick;
            state     <= PASS;
            busy      <= 1'b1;
          end
        end
        PASS: begin
          if (eop) begin
            if (pick_found) begin
              grant_idx <= pick;
              last_idx  <= pick;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbus_tx_pkt_arbiter.sv
// Randomized scoreboard bench for lbus_tx_pkt_arbiter. Sources are packet
// queues; a transaction-level model of packet ownership predicts, per cycle,
// the control outputs and the beats that must appear on the converter side.
module tb_lbus_tx_pkt_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic [SW-1:0] src;
  } exp_beat_t;

  typedef struct packed {
    logic          busy;
    logic [SW-1:0] grant;
    logic          mvalid;
    logic [N-1:0]  tready;
  } exp_ctl_t;

  logic            clk;
  logic            rst;
  logic [DW*N-1:0] s_axis_tdata;
  logic [KW*N-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tlast;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [SW-1:0]   grant_idx;
  logic            busy;

  lbus_tx_pkt_arbiter #(.NUM_SRC(N), .SEL_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .grant_idx    (grant_idx),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source packet queues and per-source presentation state
  beat_t        src_q[N][$];
  logic [N-1:0] vld;
  logic [N-1:0] hs_vec;

  // Ownership model: who holds the link, and the round-robin pointer
  bit           m_busy;
  int           m_owner;
  int           m_ptr;

  exp_beat_t    beat_q[$];
  exp_ctl_t     ctl_q[$];
  int           checks;
  int           passes;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // First source at or after start+1 (mod N) that is requesting, or -1
  function automatic int rr(input int start, input logic [N-1:0] r);
    for (int k = 1; k <= int'(N); k++) begin
      if (r[(start + k) % int'(N)]) return (start + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic gen(input int i, input int p_gen, input int maxlen);
    beat_t b;
    int    len;
    if (src_q[i].size() == 0 && $urandom_range(99) < p_gen) begin
      len = $urandom_range(maxlen, 1);
      for (int j = 0; j < len; j++) begin
        for (int w = 0; w < int'(DW / 32); w++) b.data[w*32 +: 32] = $urandom;
        b.keep = {$urandom, $urandom};
        b.last = (j == len - 1);
        src_q[i].push_back(b);
      end
    end
  endtask

  // AXI-Stream sources: a raised tvalid is held until its handshake
  task automatic drive(input int p_valid, input int p_ready, input int p_gen, input int maxlen);
    for (int i = 0; i < int'(N); i++) begin
      gen(i, p_gen, maxlen);
      if (!(vld[i] && !hs_vec[i])) begin
        vld[i] = (src_q[i].size() > 0) && ($urandom_range(99) < p_valid);
      end
      if (vld[i]) begin
        s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
        s_axis_tkeep[i*KW +: KW] = src_q[i][0].keep;
        s_axis_tlast[i]          = src_q[i][0].last;
      end else begin
        s_axis_tlast[i]          = 1'($urandom);
      end
    end
    s_axis_tvalid = vld;
    m_axis_tready = ($urandom_range(99) < p_ready);
  endtask

  // Predict this cycle's outputs from the packet-ownership rules, then advance
  task automatic model_eval();
    exp_ctl_t     e;
    exp_beat_t    eb;
    logic [N-1:0] r;
    bit           eop;
    int           nxt;
    e.busy  = m_busy;
    e.grant = SW'(m_owner);
    eop     = 1'b0;
    hs_vec  = '0;
    if (rst) begin
      e.mvalid = 1'b0;
      e.tready = '0;
      ctl_q.push_back(e);
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = N - 1;
      return;
    end
    e.mvalid = m_busy && vld[m_owner];
    e.tready = (m_busy && m_axis_tready) ? (N'(1) << m_owner) : '0;
    ctl_q.push_back(e);
    if (m_busy && vld[m_owner] && m_axis_tready) begin
      hs_vec[m_owner] = 1'b1;
      eb.b   = src_q[m_owner].pop_front();
      eb.src = SW'(m_owner);
      beat_q.push_back(eb);
      eop = eb.b.last;
    end
    if (!m_busy) begin
      nxt = rr(m_ptr, vld);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_ptr   = nxt;
        m_busy  = 1'b1;
      end
    end else if (eop) begin
      r = vld;
      r[m_owner] = 1'b0;
      nxt = rr(m_owner, r);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_ptr   = nxt;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input int p_valid, input int p_ready, input int p_gen, input int maxlen);
    @(posedge clk);
    #1;
    rst = r;
    if (r) begin
      for (int i = 0; i < int'(N); i++) src_q[i].delete();
      vld           = '0;
      s_axis_tvalid = '0;
      m_axis_tready = 1'($urandom);
    end else begin
      drive(p_valid, p_ready, p_gen, maxlen);
    end
    #1;
    model_eval();
  endtask

  // Monitor: per-cycle control check, beat check on every converter handshake
  always @(negedge clk) begin
    exp_ctl_t  e;
    exp_beat_t eb;
    if (ctl_q.size() > 0) begin
      e = ctl_q.pop_front();
      chk("busy",   DW'(busy),          DW'(e.busy));
      chk("mvalid", DW'(m_axis_tvalid), DW'(e.mvalid));
      chk("tready", DW'(s_axis_tready), DW'(e.tready));
      if (e.busy) chk("grant_idx", DW'(grant_idx), DW'(e.grant));
      if (m_axis_tvalid && m_axis_tready) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", DW'(1), DW'(0));
        end else begin
          eb = beat_q.pop_front();
          chk("beat_src",  DW'(grant_idx),    DW'(eb.src));
          chk("beat_data", m_axis_tdata,      eb.b.data);
          chk("beat_keep", DW'(m_axis_tkeep), DW'(eb.b.keep));
          chk("beat_last", DW'(m_axis_tlast), DW'(eb.b.last));
        end
      end
    end
  end

  initial begin
    bit drained;
    checks        = 0;
    passes        = 0;
    rst           = 1'b1;
    vld           = '0;
    hs_vec        = '0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    m_busy        = 1'b0;
    m_owner       = 0;
    m_ptr         = N - 1;
    repeat (2) @(posedge clk);

    // Checked reset cycles
    step(1'b1, 0, 0, 0, 1);
    step(1'b1, 0, 0, 0, 1);

    // Mixed traffic with backpressure, gaps and a mid-run reset
    for (int c = 0; c < 1500; c++) begin
      step((c == 700), 60, 70, 30, 4);
    end

    // Saturated single-beat traffic: one packet per cycle, strict rotation
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 100, 100, 100, 1);
    end

    // Back-to-back multi-beat packets with a permanently ready sink
    for (int c = 0; c < 200; c++) begin
      step(1'b0, 100, 100, 50, 4);
    end

    // Drain every queued packet with a bounded budget
    drained = 1'b0;
    for (int c = 0; c < 400 && !drained; c++) begin
      step(1'b0, 100, 100, 0, 1);
      drained = !m_busy;
      for (int i = 0; i < int'(N); i++) if (src_q[i].size() != 0) drained = 1'b0;
    end
    step(1'b0, 100, 100, 0, 1);
    @(negedge clk);
    @(posedge clk);
    chk("drain_done",    DW'(drained),       DW'(1));
    chk("beats_pending", DW'(beat_q.size()), DW'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
